seq_magnitude_comparator: RTL and testbench

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/seq_magnitude_comparator.sv | 139 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator. Operands are walked DIGIT bits per
//   cycle, most significant slice first, and compared as unsigned slices.
//   Signed compares reuse the unsigned datapath by flipping the sign bit
//   of both operands at load time.
//
//   Build option:
//     CMP_EARLY_EXIT_EN  defined   -> the first differing slice ends the
//                                     compare at once.
//                        undefined -> the first differing slice latches
//                                     the decision. The compare always
//                                     runs all N slices, so latency does
//                                     not depend on the data.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        request; A, B and signed_mode are sampled when it is accepted
//   A, B         operands, WIDTH bits
//   signed_mode  1 = two's-complement compare, 0 = unsigned compare
//   busy         high while a compare is in progress
//   done         one-cycle pulse; the result is valid
//   AGB/AEB/ALB  result (A>B, A=B, A<B); holds until the next accepted start
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             AGB,
  output logic             AEB,
  output logic             ALB
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  // The operands shift left one slice per cycle, so the slice under test
  // is always the top DIGIT bits.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] sa, sb;
  logic             accept;

  assign sa     = a_sh[WIDTH-1 -: DIGIT];
  assign sb     = b_sh[WIDTH-1 -: DIGIT];
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == COMPARE);
  assign done   = (state == DONE);

`ifndef CMP_EARLY_EXIT_EN
  // Decision latched by the first differing slice. Later slices only matter
  // while both flags are still clear.
  logic dgt, dlt;
  logic gt_n, lt_n;

  always_comb begin
    gt_n = dgt;
    lt_n = dlt;
    if (!dgt && !dlt) begin
      gt_n = (sa > sb);
      lt_n = (sa < sb);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      AGB   <= 1'b0;
      AEB   <= 1'b0;
      ALB   <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      dgt   <= 1'b0;
      dlt   <= 1'b0;
`endif
    end else if (accept) begin
      // Inverting the MSB maps two's-complement order onto unsigned order.
      a_sh  <= {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
      b_sh  <= {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
      idx   <= '0;
      AGB   <= 1'b0;
      AEB   <= 1'b0;
      ALB   <= 1'b0;
      state <= COMPARE;
`ifndef CMP_EARLY_EXIT_EN
      dgt   <= 1'b0;
      dlt   <= 1'b0;
`endif
    end else begin
      case (state)
        COMPARE: begin
          idx  <= idx + 1'b1;
          a_sh <= a_sh << DIGIT;
          b_sh <= b_sh << DIGIT;
`ifdef CMP_EARLY_EXIT_EN
          if (sa > sb) begin
            AGB   <= 1'b1;
            state <= DONE;
          end else if (sa < sb) begin
            ALB   <= 1'b1;
            state <= DONE;
          end else if (idx == LAST) begin
            AEB   <= 1'b1;
            state <= DONE;
          end
`else
          dgt <= gt_n;
          dlt <= lt_n;
          if (idx == LAST) begin
            AGB   <= gt_n;
            ALB   <= lt_n;
            AEB   <= !gt_n && !lt_n;
            state <= DONE;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [WIDTH-1:0] A = '0, B = '0;
  logic signed_mode = 1'b0;
  logic busy, done, AGB, AEB, ALB;

  int checks = 0;
  int errors = 0;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .AGB(AGB), .AEB(AEB), .ALB(ALB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {AGB,AEB,ALB} from plain arithmetic.
  function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] a, b, input logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Reference latency: number of edges after acceptance until done is high.
  function automatic int ref_lat(input logic [WIDTH-1:0] a, b);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 0; i < N; i++)
      if (((a >> (WIDTH - DIGIT*(i+1))) & 16'hF) != ((b >> (WIDTH - DIGIT*(i+1))) & 16'hF))
        return i + 1;
`endif
    return N;
  endfunction

  // One compare: start accepted at edge 0; optional start pulse injected
  // at cycle inj during COMPARE; optional check that the result holds.
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a, b, input logic s,
                         input int inj, input bit hold);
    logic [2:0] er;
    int lat;
    int k;
    er  = ref_res(a, b, s);
    lat = ref_lat(a, b);
    @(negedge clk);
    start = 1'b1; A = a; B = b; signed_mode = s;
    @(posedge clk); #1;
    start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); signed_mode = ~s;
    chk({tag, "_busy"}, busy, 1'b1);
    k = 0;
    while (k < N + 3) begin
      if (k == inj) begin start = 1'b1; A = '0; B = '0; end
      else start = 1'b0;
      @(posedge clk); #1;
      k++;
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_res"}, {AGB, AEB, ALB}, er);
    if (hold) begin
      @(posedge clk); #1;
      chk({tag, "_idle"}, {busy, done}, 2'b00);
      chk({tag, "_hold"}, {AGB, AEB, ALB}, er);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {busy, done, AGB, AEB, ALB}, 5'b0);
    @(negedge clk); rst = 1'b0;

    run_cmp("eq1234",  16'h1234, 16'h1234, 1'b0, -1, 1'b1);
    run_cmp("u8000",   16'h8000, 16'h7FFF, 1'b0, -1, 1'b1);
    run_cmp("s8000",   16'h8000, 16'h7FFF, 1'b1, -1, 1'b1);
    run_cmp("a5a6",    16'h00A5, 16'h00A6, 1'b0, -1, 1'b1);
    run_cmp("sFFFF",   16'hFFFF, 16'h0000, 1'b1, -1, 1'b1);
    run_cmp("uFFFF",   16'hFFFF, 16'h0000, 1'b0, -1, 1'b1);
    run_cmp("ignore",  16'h1234, 16'h1235, 1'b0, 1, 1'b1);
    // Start accepted in the DONE cycle of the previous compare.
    run_cmp("b2b_a",   16'h4321, 16'h4320, 1'b0, -1, 1'b0);
    run_cmp("b2b_b",   16'h0000, 16'h0000, 1'b1, -1, 1'b1);

    // Reset in the middle of a compare (sampled at edge 2).
    @(negedge clk);
    start = 1'b1; A = 16'h1234; B = 16'h1234; signed_mode = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst", {busy, done, AGB, AEB, ALB}, 5'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", {busy, done}, 2'b00);
    run_cmp("after_rst", 16'h5000, 16'h6000, 1'b0, -1, 1'b1);

    // Reset has priority over start.
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio", {busy, done, AGB, AEB, ALB}, 5'b0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // Random pairs, biased so the difference lands in any slice.
    for (int t = 0; t < 60; t++) begin
      a = WIDTH'($urandom);
      b = a;
      if ($urandom_range(0, 4) != 0)
        b = a ^ (WIDTH'($urandom_range(1, 15)) << (DIGIT * $urandom_range(0, N-1)));
      run_cmp("rand", a, b, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
